// File: rtl/u409_window_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : u409_window_decode                                            |
// | Purpose  : Registered Zorro 2 window decoder for U409. NWIN base/mask    |
// |            windows on A[23:16], programmed at run time by AUTOCONFIG.    |
// |            Samples the address at transfer start, holds a one-hot        |
// |            active-low select until TA/TEA, and times out unclaimed       |
// |            cycles.                                                       |
// | Ports    : CLK40, RESETn (async, active low)                             |
// |            TSn, A[31:12], RnW, TT, TAn, TEAn     - bus cycle inputs      |
// |            CFG_WR, CFG_IDX, CFG_BASE, CFG_MASK   - window programming    |
// |            WIN_SELn, CONFIGURED, MULTI_HIT, TIMEOUT, BUSY - outputs      |
// |            ROM_SELn, WIN_ARMED (only with U409_WRITE_ARM_EN)             |
// | Options  : U409_WRITE_ARM_EN - windows flagged in ARM_MASK route to      |
// |            ROM_SELn until armed by a write to that window.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module u409_window_decode #(
  parameter int              NWIN        = 4,
  parameter int              TIMEOUT_CYC = 64,
  parameter logic [NWIN-1:0] ARM_MASK    = '0
) (
  input  logic                                   CLK40,
  input  logic                                   RESETn,
  input  logic                                   TSn,
  input  logic [19:0]                            A,
  input  logic                                   RnW,
  input  logic [1:0]                             TT,
  input  logic                                   TAn,
  input  logic                                   TEAn,
  input  logic                                   CFG_WR,
  input  logic [$clog2(NWIN > 1 ? NWIN : 2)-1:0] CFG_IDX,
  input  logic [7:0]                             CFG_BASE,
  input  logic [7:0]                             CFG_MASK,
  output logic [NWIN-1:0]                        WIN_SELn,
  output logic [NWIN-1:0]                        CONFIGURED,
  output logic                                   MULTI_HIT,
  output logic                                   TIMEOUT,
  output logic                                   BUSY
`ifdef U409_WRITE_ARM_EN
  ,
  output logic                                   ROM_SELn,
  output logic [NWIN-1:0]                        WIN_ARMED
`endif
);

  localparam int c_IDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int c_CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_MISS   = 2'd2
  } state_t;

  // Window configuration
  logic [7:0]      r_base [NWIN];
  logic [7:0]      r_mask [NWIN];
  logic [NWIN-1:0] r_cfg;

  // Cycle tracking
  state_t          r_state,    w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [NWIN-1:0] r_win_seln, w_win_seln_nxt;
  logic            r_multi,    w_multi_nxt;
  logic            r_timeout,  w_timeout_nxt;

  logic [NWIN-1:0] w_hit;
  logic [NWIN-1:0] w_sel_n;
  logic            w_multi;
  logic            w_z2_ok;
  logic            w_ack;

`ifdef U409_WRITE_ARM_EN
  logic            r_rom_seln, w_rom_seln_nxt;
  logic [NWIN-1:0] r_armed,    w_armed_nxt;
  logic [c_IDX_W-1:0] w_first;
  logic            w_arm_req;
`endif

  // Only normal transfers inside the 16 MB Zorro 2 space are decoded.
  assign w_z2_ok = (A[19:12] == 8'h00) && (TT == 2'b00);
  assign w_ack   = !TAn || !TEAn;

  generate
    for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
      assign w_hit[gi] = w_z2_ok && r_cfg[gi] &&
                         (((A[11:4] ^ r_base[gi]) & r_mask[gi]) == 8'h00);
    end
  endgenerate

  // Lowest matching index wins: walk from the top so the last write is lowest.
  always_comb begin
    w_sel_n = '1;
`ifdef U409_WRITE_ARM_EN
    w_first = '0;
`endif
    for (int i = NWIN - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel_n    = '1;
        w_sel_n[i] = 1'b0;
`ifdef U409_WRITE_ARM_EN
        w_first    = c_IDX_W'(i);
`endif
      end
    end
  end

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi = (w_hit & (w_hit - 1'b1)) != '0;

`ifdef U409_WRITE_ARM_EN
  assign w_arm_req = ARM_MASK[w_first] && !r_armed[w_first];
`endif

  // Configuration writes never touch in-flight cycle state; a TS on the same
  // edge decodes against the values held before this edge.
  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NWIN; i++) begin
        r_base[i] <= 8'h00;
        r_mask[i] <= 8'hFF;
      end
      r_cfg <= '0;
    end else if (CFG_WR && (int'(CFG_IDX) < NWIN)) begin
      r_base[CFG_IDX] <= CFG_BASE;
      r_mask[CFG_IDX] <= CFG_MASK;
      r_cfg[CFG_IDX]  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_win_seln_nxt = r_win_seln;
    w_multi_nxt    = 1'b0;
    w_timeout_nxt  = 1'b0;
`ifdef U409_WRITE_ARM_EN
    w_rom_seln_nxt = r_rom_seln;
    w_armed_nxt    = r_armed;
`endif
    case (r_state)
      S_IDLE: begin
        if (!TSn) begin
          if (|w_hit) begin
            w_state_nxt = S_ACTIVE;
            w_multi_nxt = w_multi;
`ifdef U409_WRITE_ARM_EN
            // Unarmed protected window: steer to ROM; a write arms it for
            // later cycles but is itself still served by the ROM.
            if (w_arm_req) begin
              w_rom_seln_nxt = 1'b0;
              if (!RnW) begin
                w_armed_nxt[w_first] = 1'b1;
              end
            end else begin
              w_win_seln_nxt = w_sel_n;
            end
`else
            w_win_seln_nxt = w_sel_n;
`endif
          end else begin
            w_state_nxt = S_MISS;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_ACTIVE: begin
        if (w_ack) begin
          w_state_nxt    = S_IDLE;
          w_win_seln_nxt = '1;
`ifdef U409_WRITE_ARM_EN
          w_rom_seln_nxt = 1'b1;
`endif
        end
      end
      S_MISS: begin
        // Another responder claiming the cycle takes priority over expiry.
        if (w_ack) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_win_seln_nxt = '1;
`ifdef U409_WRITE_ARM_EN
        w_rom_seln_nxt = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_win_seln <= '1;
      r_multi    <= 1'b0;
      r_timeout  <= 1'b0;
`ifdef U409_WRITE_ARM_EN
      r_rom_seln <= 1'b1;
      r_armed    <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_win_seln <= w_win_seln_nxt;
      r_multi    <= w_multi_nxt;
      r_timeout  <= w_timeout_nxt;
`ifdef U409_WRITE_ARM_EN
      r_rom_seln <= w_rom_seln_nxt;
      r_armed    <= w_armed_nxt;
`endif
    end
  end

  assign WIN_SELn   = r_win_seln;
  assign CONFIGURED = r_cfg;
  assign MULTI_HIT  = r_multi;
  assign TIMEOUT    = r_timeout;
  assign BUSY       = (r_state != S_IDLE);
`ifdef U409_WRITE_ARM_EN
  assign ROM_SELn   = r_rom_seln;
  assign WIN_ARMED  = r_armed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_u409_window_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_u409_window_decode                                         |
// | Purpose  : Self-checking bench for u409_window_decode: directed table,   |
// |            multi-cycle corner sequences, and randomized transactions     |
// |            against a transaction-level reference model.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_u409_window_decode;

  localparam int NWIN = 4;
  localparam int TO   = 64;
`ifdef U409_WRITE_ARM_EN
  localparam logic [3:0] c_ARM = 4'h1;
`else
  localparam logic [3:0] c_ARM = 4'h0;
`endif

  logic        CLK40 = 1'b0;
  logic        RESETn = 1'b0;
  logic        TSn = 1'b1, RnW = 1'b1, TAn = 1'b1, TEAn = 1'b1, CFG_WR = 1'b0;
  logic [19:0] A = '0;
  logic [1:0]  TT = '0, CFG_IDX = '0;
  logic [7:0]  CFG_BASE = '0, CFG_MASK = 8'hFF;
  logic [3:0]  WIN_SELn, CONFIGURED;
  logic        MULTI_HIT, TIMEOUT, BUSY;
`ifdef U409_WRITE_ARM_EN
  logic        ROM_SELn;
  logic [3:0]  WIN_ARMED;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_base [4];
  logic [7:0] m_mask [4];
  logic [3:0] m_cfg;
  logic [3:0] m_armed;

  always #5 CLK40 = ~CLK40;

  u409_window_decode #(
    .NWIN(NWIN), .TIMEOUT_CYC(TO), .ARM_MASK(c_ARM)
  ) dut (
    .CLK40(CLK40), .RESETn(RESETn), .TSn(TSn), .A(A), .RnW(RnW), .TT(TT),
    .TAn(TAn), .TEAn(TEAn), .CFG_WR(CFG_WR), .CFG_IDX(CFG_IDX),
    .CFG_BASE(CFG_BASE), .CFG_MASK(CFG_MASK), .WIN_SELn(WIN_SELn),
    .CONFIGURED(CONFIGURED), .MULTI_HIT(MULTI_HIT), .TIMEOUT(TIMEOUT), .BUSY(BUSY)
`ifdef U409_WRITE_ARM_EN
    , .ROM_SELn(ROM_SELn), .WIN_ARMED(WIN_ARMED)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK40);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 4; i++) begin
      m_base[i] = 8'h00;
      m_mask[i] = 8'hFF;
    end
    m_cfg   = '0;
    m_armed = '0;
  endtask

  // Decode from the window rules directly; arms a window on a qualifying write.
  function automatic void predict(input logic [19:0] a, input logic [1:0] tt, input logic rnw,
                                  output logic [3:0] sel, output logic multi,
                                  output logic rom, output logic hit_any);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 4; i++) begin
      if (a[19:12] == 8'h00 && tt == 2'b00 && m_cfg[i] &&
          ((a[11:4] ^ m_base[i]) & m_mask[i]) == 8'h00) begin
        n++;
        if (k < 0) k = i;
      end
    end
    sel = 4'hF; rom = 1'b1; multi = (n > 1); hit_any = (n > 0);
    if (k >= 0) begin
      if (c_ARM[k] && !m_armed[k]) begin
        rom = 1'b0;
        if (!rnw) m_armed[k] = 1'b1;
      end else begin
        sel[k] = 1'b0;
      end
    end
  endfunction

  task automatic cfg(input int idx, input logic [7:0] b, input logic [7:0] m);
    CFG_WR = 1'b1; CFG_IDX = 2'(idx); CFG_BASE = b; CFG_MASK = m;
    tick;
    CFG_WR = 1'b0;
    m_base[idx] = b; m_mask[idx] = m; m_cfg[idx] = 1'b1;
    check("configured", 32'(CONFIGURED), 32'(m_cfg));
  endtask

  // One bus cycle terminated by TA (or TEA) ta_dly edges after the TS edge.
  task automatic ts_cycle(input string name, input logic [19:0] a, input logic [1:0] tt,
                          input logic rnw, input int ta_dly, input logic use_tea,
                          input logic [3:0] exp_sel, input logic exp_multi,
                          input logic exp_rom, input logic rnd_ts);
    A = a; TT = tt; RnW = rnw; TSn = 1'b0;
    tick;
    TSn = 1'b1; CFG_WR = 1'b0;
    check({name, ":sel"}, 32'(WIN_SELn), 32'(exp_sel));
    check({name, ":multi"}, 32'(MULTI_HIT), 32'(exp_multi));
    check({name, ":busy"}, 32'(BUSY), 32'd1);
`ifdef U409_WRITE_ARM_EN
    check({name, ":rom"}, 32'(ROM_SELn), 32'(exp_rom));
`else
    if (exp_rom !== 1'b1) check({name, ":rom_expect"}, 32'(exp_rom), 32'd1);
`endif
    for (int d = 1; d < ta_dly; d++) begin
      if (rnd_ts) begin
        TSn = 1'($urandom_range(0, 1));
        A   = 20'($urandom);
      end
      tick;
      check({name, ":hold_sel"}, 32'(WIN_SELn), 32'(exp_sel));
      check({name, ":hold_multi"}, 32'(MULTI_HIT), 32'd0);
      check({name, ":hold_to"}, 32'(TIMEOUT), 32'd0);
      check({name, ":hold_busy"}, 32'(BUSY), 32'd1);
    end
    if (use_tea) TEAn = 1'b0; else TAn = 1'b0;
    tick;
    TAn = 1'b1; TEAn = 1'b1; TSn = 1'b1;
    check({name, ":end_sel"}, 32'(WIN_SELn), 32'hF);
    check({name, ":end_busy"}, 32'(BUSY), 32'd0);
    check({name, ":end_to"}, 32'(TIMEOUT), 32'd0);
    check({name, ":end_multi"}, 32'(MULTI_HIT), 32'd0);
`ifdef U409_WRITE_ARM_EN
    check({name, ":end_rom"}, 32'(ROM_SELn), 32'd1);
`endif
  endtask

  // Unclaimed cycle left to expire.
  task automatic miss_timeout(input string name, input logic [19:0] a, input logic [1:0] tt);
    A = a; TT = tt; RnW = 1'b1; TSn = 1'b0;
    tick;
    TSn = 1'b1; CFG_WR = 1'b0;
    check({name, ":sel"}, 32'(WIN_SELn), 32'hF);
    check({name, ":busy"}, 32'(BUSY), 32'd1);
    for (int c = 1; c < TO; c++) begin
      tick;
      check({name, ":early_to"}, 32'(TIMEOUT), 32'd0);
    end
    tick;
    check({name, ":to_pulse"}, 32'(TIMEOUT), 32'd1);
    check({name, ":to_idle"}, 32'(BUSY), 32'd0);
    check({name, ":to_sel"}, 32'(WIN_SELn), 32'hF);
    tick;
    check({name, ":to_clear"}, 32'(TIMEOUT), 32'd0);
  endtask

  typedef struct {
    logic [19:0] a;
    logic [1:0]  tt;
    int          dly;
    logic        tea;
    logic [3:0]  sel;
    logic        multi;
  } vec_t;

  vec_t vt [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] e_sel;
    logic       e_multi, e_rom, e_hit;
    logic [7:0] hb, mb, mk;
    logic [1:0] tt;
    logic [19:0] a;
    logic       rnw, cc;
    int         w, cw;
    logic [7:0] cb, cm;

    vt[0] = '{20'h00E91, 2'b00, 3, 1'b0, 4'b1110, 1'b0};
    vt[1] = '{20'h00400, 2'b00, 2, 1'b1, 4'b1101, 1'b0};
    vt[2] = '{20'h00410, 2'b00, 1, 1'b0, 4'b1101, 1'b1};
    vt[3] = '{20'h00E91, 2'b01, 2, 1'b0, 4'b1111, 1'b0};
    vt[4] = '{20'h01E91, 2'b00, 2, 1'b1, 4'b1111, 1'b0};
    vt[5] = '{20'h00E81, 2'b00, 1, 1'b0, 4'b1111, 1'b0};
    vt[6] = '{20'h00000, 2'b00, 2, 1'b0, 4'b1111, 1'b0};
    vt[7] = '{20'h0041F, 2'b00, 4, 1'b0, 4'b1101, 1'b1};

    model_reset();
    RESETn = 1'b0;
    repeat (2) @(posedge CLK40);
    #1;
    check("rst:sel", 32'(WIN_SELn), 32'hF);
    check("rst:configured", 32'(CONFIGURED), 32'h0);
    check("rst:multi", 32'(MULTI_HIT), 32'd0);
    check("rst:timeout", 32'(TIMEOUT), 32'd0);
    check("rst:busy", 32'(BUSY), 32'd0);
`ifdef U409_WRITE_ARM_EN
    check("rst:rom", 32'(ROM_SELn), 32'd1);
    check("rst:armed", 32'(WIN_ARMED), 32'd0);
`endif
    RESETn = 1'b1;
    tick;

    cfg(0, 8'hE9, 8'hFF);
    cfg(1, 8'h40, 8'hFE);
    cfg(2, 8'h41, 8'hFF);

`ifdef U409_WRITE_ARM_EN
    ts_cycle("arm_rd", 20'h00E91, 2'b00, 1'b1, 2, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    check("arm_rd:armed", 32'(WIN_ARMED), 32'h0);
    ts_cycle("arm_wr", 20'h00E91, 2'b00, 1'b0, 2, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    check("arm_wr:armed", 32'(WIN_ARMED), 32'h1);
    m_armed[0] = 1'b1;
    ts_cycle("armed_rd", 20'h00E91, 2'b00, 1'b1, 2, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 8; i++) begin
      ts_cycle($sformatf("vec%0d", i), vt[i].a, vt[i].tt, 1'b1, vt[i].dly, vt[i].tea,
               vt[i].sel, vt[i].multi, 1'b1, 1'b0);
    end

    miss_timeout("timeout", 20'h00A00, 2'b00);
    ts_cycle("miss_ta10", 20'h00A00, 2'b00, 1'b1, 10, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);

    // Reprogram win0 on the TS edge: that decode still sees base E9.
    CFG_WR = 1'b1; CFG_IDX = 2'd0; CFG_BASE = 8'h20; CFG_MASK = 8'hFF;
    ts_cycle("cfg_same_edge", 20'h00200, 2'b00, 1'b1, 2, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
    m_base[0] = 8'h20; m_mask[0] = 8'hFF;
    ts_cycle("cfg_next_ts", 20'h00200, 2'b00, 1'b1, 2, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an active cycle.
    A = 20'h00200; TT = 2'b00; RnW = 1'b1; TSn = 1'b0;
    tick;
    TSn = 1'b1;
    check("pre_rst:sel", 32'(WIN_SELn), 32'hE);
    #2 RESETn = 1'b0;
    #1;
    check("async_rst:sel", 32'(WIN_SELn), 32'hF);
    check("async_rst:configured", 32'(CONFIGURED), 32'h0);
    check("async_rst:busy", 32'(BUSY), 32'd0);
    #1 RESETn = 1'b1;
    model_reset();
    tick;
    ts_cycle("post_rst_miss", 20'h00200, 2'b00, 1'b1, 2, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0:       mk = 8'hFE;
          1:       mk = 8'hFC;
          2:       mk = 8'hF0;
          3:       mk = 8'h00;
          default: mk = 8'hFF;
        endcase
        cfg($urandom_range(0, 3), 8'($urandom), mk);
      end
      hb  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      w   = $urandom_range(0, 3);
      mb  = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                        : (m_base[w] ^ (8'($urandom) & ~m_mask[w]));
      tt  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      a   = {hb, mb, 4'($urandom)};
      rnw = 1'($urandom_range(0, 1));
      cc  = ($urandom_range(0, 9) == 0);
      cw  = $urandom_range(0, 3);
      cb  = 8'($urandom);
      cm  = 8'hFF;
      if (cc) begin
        CFG_WR = 1'b1; CFG_IDX = 2'(cw); CFG_BASE = cb; CFG_MASK = cm;
      end
      predict(a, tt, rnw, e_sel, e_multi, e_rom, e_hit);
      if (!e_hit && $urandom_range(0, 15) == 0) begin
        miss_timeout($sformatf("rnd%0d_to", it), a, tt);
      end else begin
        ts_cycle($sformatf("rnd%0d", it), a, tt, rnw, $urandom_range(1, 6),
                 1'($urandom_range(0, 1)), e_sel, e_multi, e_rom, 1'b1);
      end
      if (cc) begin
        m_base[cw] = cb; m_mask[cw] = cm; m_cfg[cw] = 1'b1;
        check($sformatf("rnd%0d_configured", it), 32'(CONFIGURED), 32'(m_cfg));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
